mem_req_seq: RTL and testbench
==============================

MEM_REQ_SEQ -- requirements
Module: mem_req_seq

Interface
REQ-001 Parameters: WORD_SIZE, default 32, data word width; CL_SIZE_WIDTH, default 512, cache-line width; ADDR_BITCOUNT, default 64, address width; FILL_COUNT = CL_SIZE_WIDTH/WORD_SIZE is a derived local.
REQ-002 clk  in  1  clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid / req_ready  in / out  1 / 1  line-request handshake from the cache/MSHR side.
REQ-005 req_write  in  1  request type: 1 = line write, 0 = line read.
REQ-006 req_addr  in  ADDR_BITCOUNT  line address.
REQ-007 req_wdata  in  CL_SIZE_WIDTH  write line; word k is bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE].
REQ-008 resp_valid / resp_ready  out / in  1 / 1  completion handshake.
REQ-009 resp_write  out  1  type of the completed request.
REQ-010 resp_rdata  out  CL_SIZE_WIDTH  read line, same word order as req_wdata.
REQ-011 mc_ready  in  1  memory controller initialised.
REQ-012 mc_tx_done / mc_rd_valid  in / in  1 / 1  memory-controller transfer-done and read-word-valid strobes.
REQ-013 mc_rdata_word  in  WORD_SIZE  read word from the memory controller.
REQ-014 mc_op  out  2  opcode: IDLE=2'b00, READ=2'b01, WRITE=2'b11.
REQ-015 mc_wdata_word / mc_addr  out / out  WORD_SIZE / ADDR_BITCOUNT  write word; registered line address.

Function
REQ-016 States: S_IDLE, S_W_ISSUE, S_W_STREAM, S_W_WAIT, S_R_WAIT, S_RESP.
REQ-017 req_ready = 1 only in S_IDLE with mc_ready = 1.
REQ-018 On acceptance: latch req_addr, req_write and req_wdata; clear word counter wcnt; go to S_W_ISSUE if write, else S_R_WAIT.
REQ-019 mc_op = WRITE in S_W_ISSUE, S_W_STREAM and S_W_WAIT; READ in S_R_WAIT; IDLE in every other state.
REQ-020 mc_addr holds the latched address from acceptance until the next acceptance.
REQ-021 S_W_ISSUE lasts exactly 1 cycle, then S_W_STREAM.
REQ-022 S_W_STREAM: mc_wdata_word = word[wcnt], wcnt increments every cycle; after the cycle with wcnt = FILL_COUNT-1, go to S_W_WAIT.
REQ-023 Write stream is FILL_COUNT consecutive cycles, word 0 first, with no stalls.
REQ-024 S_W_WAIT holds until mc_tx_done = 1, then S_RESP.
REQ-025 S_R_WAIT: on each mc_rd_valid, store mc_rdata_word into line word[wcnt] and increment wcnt.
REQ-026 mc_rd_valid together with mc_tx_done stores the word and then goes to S_RESP.
REQ-027 wcnt is FILL_BITS wide and wraps; more than FILL_COUNT read words overwrite from word 0.
REQ-028 S_RESP: resp_valid = 1, resp_rdata/resp_write stable; leave to S_IDLE when resp_ready = 1.
REQ-029 mc_op is IDLE on the cycle after mc_tx_done, so the controller never re-triggers.
REQ-030 mc_tx_done / mc_rd_valid outside S_W_WAIT / S_R_WAIT are ignored.
REQ-031 mc_ready low in S_IDLE blocks acceptance; mc_ready falling mid-transaction is ignored.
REQ-032 Write latency: acceptance edge to first S_RESP cycle = FILL_COUNT + 2 cycles + W_WAIT cycles.

Reset
REQ-033 rst_n low asynchronously forces S_IDLE, wcnt = 0, stored line/address = 0 and all outputs 0 (mc_op = IDLE); mid-transaction data is discarded with no response.

Configuration
REQ-034 With MEM_REQ_SEQ_STATS_EN defined, add outputs stat_rd_cnt and stat_wr_cnt (32 bits each, out), incremented on S_RESP exit per type, wrapping at 2^32, cleared by reset.
REQ-035 Without MEM_REQ_SEQ_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-036 The mc_op opcode enum (IDLE/READ/WRITE) lives in shared package mem_pkg and is used by this block and the memory controller; the state enum is local.
REQ-037 Statistics live in sub-module mem_req_seq_stats, instantiated only under MEM_REQ_SEQ_STATS_EN.

Verification (WORD_SIZE=32, CL_SIZE_WIDTH=512)
REQ-038 Write: req_wdata word k = 32'hA000_0000+k, addr 64'h1000 -> S_W_ISSUE 1 cycle, then 16 cycles of mc_wdata_word A0000000..A000000F, mc_op=WRITE until mc_tx_done, resp_valid next cycle with resp_write=1.
REQ-039 Read: 16 mc_rd_valid pulses with words 32'hB000_0000+k, mc_tx_done on the 16th -> resp_rdata word k = B0000000+k, mc_op=IDLE the cycle after.
REQ-040 mc_ready=0 with req_valid=1 for 10 cycles -> req_ready=0 and mc_op=IDLE throughout; acceptance on the first cycle mc_ready=1.
REQ-041 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, no new acceptance.
REQ-042 rst_n asserted at stream word 7 -> all outputs 0 immediately; after release a new read completes correctly.
REQ-043 MEM_REQ_SEQ_STATS_EN: 3 reads + 2 writes -> stat_rd_cnt=3, stat_wr_cnt=2.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the line-request sequencers and the memory
// controller.
//   mc_op_e   : memory-controller opcode (IDLE / READ / WRITE)
//   fill_bits : width of a counter that indexes the words of one cache line
package mem_pkg;

  typedef enum logic [1:0] {
    MC_OP_IDLE  = 2'b00,
    MC_OP_READ  = 2'b01,
    MC_OP_WRITE = 2'b11
  } mc_op_e;

  // A single-word line still needs a 1-bit counter so the declarations stay legal.
  function automatic int fill_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_seq_stats.sv
// mem_req_seq_stats: completed-request counters for mem_req_seq.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (clears both counters)
//   resp_done     : one-cycle pulse when a response handshake completes
//   resp_write    : type of the completing request (1 = write, 0 = read)
//   stat_rd_cnt   : completed line reads, wraps at 2^32
//   stat_wr_cnt   : completed line writes, wraps at 2^32
module mem_req_seq_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resp_done,
  input  logic        resp_write,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (resp_done) begin
      if (resp_write) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      else            stat_rd_cnt <= stat_rd_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_req_seq.sv
// mem_req_seq: turns one cache-line request into a word-serial transfer with
// the memory controller, then returns a completion response.
//
// Optional build macro: MEM_REQ_SEQ_STATS_EN adds stat_rd_cnt / stat_wr_cnt
// (completed reads / writes, 32-bit wrapping).
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid / req_ready      : line request handshake
//   req_write, req_addr        : request type (1 = write) and line address
//   req_wdata                  : write line, word k at [(k+1)*WORD_SIZE-1 : k*WORD_SIZE]
//   resp_valid / resp_ready    : completion handshake
//   resp_write, resp_rdata     : completed request type and read line
//   mc_ready                   : memory controller initialised
//   mc_tx_done, mc_rd_valid    : controller transfer-done / read-word strobes
//   mc_rdata_word              : read word from the controller
//   mc_op                      : opcode to the controller (mem_pkg::mc_op_e)
//   mc_wdata_word, mc_addr     : streamed write word, registered line address
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a request; ready only while mc_ready is high
// S_W_ISSUE  | one cycle of WRITE opcode before the data stream starts
// S_W_STREAM | one write word per cycle, word 0 first, FILL_COUNT cycles
// S_W_WAIT   | WRITE held until the controller reports mc_tx_done
// S_R_WAIT   | READ; each mc_rd_valid word lands at line[wcnt]; ends on mc_tx_done
// S_RESP     | response presented until resp_ready
module mem_req_seq
  import mem_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_BITCOUNT-1:0] req_addr,
  input  logic [CL_SIZE_WIDTH-1:0] req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_write,
  output logic [CL_SIZE_WIDTH-1:0] resp_rdata,
  input  logic                     mc_ready,
  input  logic                     mc_tx_done,
  input  logic                     mc_rd_valid,
  input  logic [WORD_SIZE-1:0]     mc_rdata_word,
  output logic [1:0]               mc_op,
  output logic [WORD_SIZE-1:0]     mc_wdata_word,
  output logic [ADDR_BITCOUNT-1:0] mc_addr
`ifdef MEM_REQ_SEQ_STATS_EN
  ,
  output logic [31:0]              stat_rd_cnt,
  output logic [31:0]              stat_wr_cnt
`endif
);

  localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int FILL_BITS  = fill_bits(FILL_COUNT);
  localparam logic [FILL_BITS-1:0] LAST_WORD = FILL_BITS'(FILL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ISSUE,
    S_W_STREAM,
    S_W_WAIT,
    S_R_WAIT,
    S_RESP
  } state_e;

  state_e                                   state_q, state_d;
  logic [FILL_BITS-1:0]                     wcnt_q;
  logic [ADDR_BITCOUNT-1:0]                 addr_q;
  logic                                     write_q;
  logic [FILL_COUNT-1:0][WORD_SIZE-1:0]     line_q;

  logic accept;
  logic rd_store;
  logic wcnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mc_op         = MC_OP_IDLE;
    mc_wdata_word = '0;
    accept        = 1'b0;
    rd_store      = 1'b0;
    wcnt_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is held.
        req_ready = rst_n && mc_ready;
        if (req_valid && mc_ready) begin
          accept  = 1'b1;
          state_d = req_write ? S_W_ISSUE : S_R_WAIT;
        end
      end
      S_W_ISSUE: begin
        mc_op   = MC_OP_WRITE;
        state_d = S_W_STREAM;
      end
      S_W_STREAM: begin
        mc_op         = MC_OP_WRITE;
        mc_wdata_word = line_q[wcnt_q];
        wcnt_inc      = 1'b1;
        if (wcnt_q == LAST_WORD) state_d = S_W_WAIT;
      end
      S_W_WAIT: begin
        mc_op = MC_OP_WRITE;
        if (mc_tx_done) state_d = S_RESP;
      end
      S_R_WAIT: begin
        mc_op = MC_OP_READ;
        if (mc_rd_valid) begin
          rd_store = 1'b1;
          wcnt_inc = 1'b1;
        end
        if (mc_tx_done) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line register holds the write data during a write and collects the
  // read words during a read, so one buffer serves both directions. wcnt
  // wraps, so surplus read words overwrite from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      line_q  <= '0;
    end else if (accept) begin
      wcnt_q  <= '0;
      addr_q  <= req_addr;
      write_q <= req_write;
      line_q  <= req_wdata;
    end else begin
      if (rd_store) line_q[wcnt_q] <= mc_rdata_word;
      if (wcnt_inc) wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign mc_addr    = addr_q;
  assign resp_write = write_q;
  assign resp_rdata = line_q;

`ifdef MEM_REQ_SEQ_STATS_EN
  logic resp_done;
  assign resp_done = (state_q == S_RESP) && resp_ready;

  mem_req_seq_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .resp_done   (resp_done),
    .resp_write  (write_q),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_req_seq.sv
`timescale 1ns/1ps
module tb_mem_req_seq;

  localparam int WS  = 32;
  localparam int CLW = 512;
  localparam int AW  = 64;
  localparam int FC  = CLW / WS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid, req_ready, req_write;
  logic [AW-1:0]  req_addr;
  logic [CLW-1:0] req_wdata;
  logic           resp_valid, resp_ready, resp_write;
  logic [CLW-1:0] resp_rdata;
  logic           mc_ready, mc_tx_done, mc_rd_valid;
  logic [WS-1:0]  mc_rdata_word, mc_wdata_word;
  logic [1:0]     mc_op;
  logic [AW-1:0]  mc_addr;
`ifdef MEM_REQ_SEQ_STATS_EN
  logic [31:0]    stat_rd_cnt, stat_wr_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_seq #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CLW), .ADDR_BITCOUNT(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_write    (resp_write),
    .resp_rdata    (resp_rdata),
    .mc_ready      (mc_ready),
    .mc_tx_done    (mc_tx_done),
    .mc_rd_valid   (mc_rd_valid),
    .mc_rdata_word (mc_rdata_word),
    .mc_op         (mc_op),
    .mc_wdata_word (mc_wdata_word),
    .mc_addr       (mc_addr)
`ifdef MEM_REQ_SEQ_STATS_EN
    ,
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_wr_cnt   (stat_wr_cnt)
`endif
  );

  task automatic chk(input string name, input logic [CLW-1:0] act, input logic [CLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 write, 2 read, 3 response),
  // cycles since a write was accepted, read words received, and the line.
  int             m_phase = 0;
  int             m_age   = 0;
  int             m_cnt   = 0;
  logic [AW-1:0]  m_addr;
  logic           m_write;
  logic [WS-1:0]  m_line [FC];
  int unsigned    m_rd_n = 0;
  int unsigned    m_wr_n = 0;
  logic [CLW-1:0] line_flat;
  int             target = 16;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_age <= 0; m_cnt <= 0;
      m_addr  <= '0; m_write <= 1'b0;
      for (int k = 0; k < FC; k++) m_line[k] <= '0;
      m_rd_n  <= 0; m_wr_n <= 0;
    end else begin
      case (m_phase)
        0: if (req_valid && mc_ready) begin
          m_addr  <= req_addr;
          m_write <= req_write;
          for (int k = 0; k < FC; k++) m_line[k] <= req_wdata[k*WS +: WS];
          m_age   <= 0;
          m_cnt   <= 0;
          m_phase <= req_write ? 1 : 2;
        end
        1: begin
          // one issue cycle, FC stream cycles, then waiting for tx_done
          m_age <= m_age + 1;
          if (m_age >= FC + 1 && mc_tx_done) m_phase <= 3;
        end
        2: begin
          if (mc_rd_valid) begin
            m_line[m_cnt % FC] <= mc_rdata_word;
            m_cnt <= m_cnt + 1;
          end
          if (mc_tx_done) m_phase <= 3;
        end
        default: if (resp_ready) begin
          m_phase <= 0;
          if (m_write) m_wr_n <= m_wr_n + 1;
          else         m_rd_n <= m_rd_n + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < FC; k++) line_flat[k*WS +: WS] = m_line[k];
    chk("req_ready", CLW'(req_ready), CLW'(rst_n && m_phase == 0 && mc_ready));
    chk("mc_op", CLW'(mc_op), CLW'((m_phase == 1) ? 2'b11 : (m_phase == 2) ? 2'b01 : 2'b00));
    chk("mc_wdata_word", CLW'(mc_wdata_word),
        CLW'((m_phase == 1 && m_age >= 1 && m_age <= FC) ? m_line[m_age-1] : 32'h0));
    chk("mc_addr", CLW'(mc_addr), CLW'(m_addr));
    chk("resp_valid", CLW'(resp_valid), CLW'(m_phase == 3));
    if (m_phase == 3 || !rst_n) chk("resp_write", CLW'(resp_write), CLW'(m_write));
    if ((m_phase == 3 && !m_write) || !rst_n) chk("resp_rdata", resp_rdata, line_flat);
`ifdef MEM_REQ_SEQ_STATS_EN
    chk("stat_rd_cnt", CLW'(stat_rd_cnt), CLW'(m_rd_n));
    chk("stat_wr_cnt", CLW'(stat_wr_cnt), CLW'(m_wr_n));
`endif
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [CLW-1:0] line, input int wait_cyc);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = line; mc_ready = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    #3;
    chk("w_issue_op", CLW'(mc_op), CLW'(2'b11));
    chk("w_issue_addr", CLW'(mc_addr), CLW'(a));
    for (int k = 0; k < FC; k++) begin
      @(posedge clk); #5;
      chk("w_stream_word", CLW'(mc_wdata_word), CLW'(line[k*WS +: WS]));
    end
    for (int w = 0; w < wait_cyc; w++) begin
      @(posedge clk); #5;
      chk("w_wait_op", CLW'(mc_op), CLW'(2'b11));
    end
    @(posedge clk); #2; mc_tx_done = 1'b1;
    @(posedge clk); #2; mc_tx_done = 1'b0;
    #3;
    chk("w_resp_valid", CLW'(resp_valid), CLW'(1'b1));
    chk("w_resp_write", CLW'(resp_write), CLW'(1'b1));
    chk("w_resp_op_idle", CLW'(mc_op), CLW'(2'b00));
    @(posedge clk); #2; resp_ready = 1'b1;
    @(posedge clk); #2; resp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [WS-1:0] base, input int nwords, input int hold);
    logic [CLW-1:0] exp_line;
    exp_line = '0;
    for (int k = 0; k < nwords; k++) exp_line[(k % FC)*WS +: WS] = base + WS'(k);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; mc_ready = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      mc_rd_valid = 1'b1; mc_rdata_word = base + WS'(k); mc_tx_done = (k == nwords - 1);
      @(posedge clk); #2;
    end
    mc_rd_valid = 1'b0; mc_tx_done = 1'b0;
    #3;
    chk("r_resp_valid", CLW'(resp_valid), CLW'(1'b1));
    chk("r_resp_write", CLW'(resp_write), CLW'(1'b0));
    chk("r_op_idle_after_done", CLW'(mc_op), CLW'(2'b00));
    chk("r_resp_rdata", resp_rdata, exp_line);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      req_valid = 1'b1; req_write = 1'b1;
      #3;
      chk("hold_resp_valid", CLW'(resp_valid), CLW'(1'b1));
      chk("hold_resp_rdata", resp_rdata, exp_line);
      chk("hold_req_ready", CLW'(req_ready), CLW'(1'b0));
    end
    @(posedge clk); #2; resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #2; resp_ready = 1'b0;
    #3;
    chk("r_resp_released", CLW'(resp_valid), CLW'(1'b0));
    chk("r_no_new_accept", CLW'(mc_op), CLW'(2'b00));
  endtask

  initial begin
    logic [CLW-1:0] line;
    rst_n = 1'b0;
    m_addr = '0; m_write = 1'b0;
    for (int k = 0; k < FC; k++) m_line[k] = '0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mc_ready = 1'b1; mc_tx_done = 1'b0; mc_rd_valid = 1'b0;
    mc_rdata_word = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req_ready", CLW'(req_ready), CLW'(1'b0));
    chk("rst_mc_op", CLW'(mc_op), CLW'(2'b00));
    chk("rst_resp_valid", CLW'(resp_valid), CLW'(1'b0));
    chk("rst_mc_addr", CLW'(mc_addr), CLW'(64'h0));
    @(posedge clk); #2;
    req_valid = 1'b0; rst_n = 1'b1;

    // Write of A0000000+k to 0x1000 with three extra wait cycles
    for (int k = 0; k < FC; k++) line[k*WS +: WS] = 32'hA000_0000 + WS'(k);
    do_write(64'h1000, line, 3);

    // Read of B0000000+k, response held for five cycles
    do_read(64'h2000, 32'hB000_0000, 16, 5);

    // mc_ready low blocks acceptance for ten cycles
    @(posedge clk); #2;
    mc_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h3000;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("nrdy_req_ready", CLW'(req_ready), CLW'(1'b0));
      chk("nrdy_mc_op", CLW'(mc_op), CLW'(2'b00));
      @(posedge clk); #2;
    end
    mc_ready = 1'b1;
    #3;
    chk("rdy_req_ready", CLW'(req_ready), CLW'(1'b1));
    @(posedge clk); #2; req_valid = 1'b0;
    #3;
    chk("rdy_accept_op", CLW'(mc_op), CLW'(2'b01));
    chk("rdy_accept_addr", CLW'(mc_addr), CLW'(64'h3000));
    @(posedge clk); #2; mc_tx_done = 1'b1;
    @(posedge clk); #2; mc_tx_done = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #2; resp_ready = 1'b0;

    // Reset while write word 7 is on the bus
    for (int k = 0; k < FC; k++) line[k*WS +: WS] = 32'hC000_0000 + WS'(k);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h5000; req_wdata = line;
    @(posedge clk); #2; req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #5;
    chk("pre_rst_word7", CLW'(mc_wdata_word), CLW'(32'hC000_0007));
    #1; rst_n = 1'b0;
    #1;
    chk("rst_mid_op", CLW'(mc_op), CLW'(2'b00));
    chk("rst_mid_wdata", CLW'(mc_wdata_word), CLW'(32'h0));
    chk("rst_mid_addr", CLW'(mc_addr), CLW'(64'h0));
    chk("rst_mid_req_ready", CLW'(req_ready), CLW'(1'b0));
    chk("rst_mid_resp_valid", CLW'(resp_valid), CLW'(1'b0));
    chk("rst_mid_rdata", resp_rdata, CLW'(0));
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    do_read(64'h4000, 32'hD000_0000, 16, 0);

    // Read with 18 words: words 16 and 17 wrap onto slots 0 and 1
    do_read(64'h6000, 32'hE000_0000, 18, 1);
    do_read(64'h7000, 32'hF000_0000, 16, 0);
    for (int k = 0; k < FC; k++) line[k*WS +: WS] = $urandom;
    do_write(64'h8000, line, 0);
    for (int k = 0; k < FC; k++) line[k*WS +: WS] = $urandom;
    do_write(64'h9000, line, 1);
`ifdef MEM_REQ_SEQ_STATS_EN
    #3;
    chk("stats_reads", CLW'(stat_rd_cnt), CLW'(32'd3));
    chk("stats_writes", CLW'(stat_wr_cnt), CLW'(32'd2));
`endif

    // Randomized traffic with spurious strobes, ready gaps and long reads
    repeat (4000) begin
      @(posedge clk); #2;
      mc_ready      = ($urandom_range(0, 4) != 0);
      mc_rdata_word = $urandom;
      mc_rd_valid   = 1'b0;
      mc_tx_done    = 1'b0;
      resp_ready    = 1'($urandom_range(0, 1));
      case (m_phase)
        0: begin
          target = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 19)) : 16;
          req_valid = ($urandom_range(0, 2) != 0);
          req_write = 1'($urandom_range(0, 1));
          req_addr  = {$urandom, $urandom};
          for (int k = 0; k < FC; k++) req_wdata[k*WS +: WS] = $urandom;
          mc_rd_valid = ($urandom_range(0, 5) == 0);
          mc_tx_done  = ($urandom_range(0, 5) == 0);
        end
        1: begin
          req_valid   = 1'($urandom_range(0, 1));
          mc_tx_done  = ($urandom_range(0, 3) == 0);
          mc_rd_valid = ($urandom_range(0, 3) == 0);
        end
        2: begin
          req_valid   = 1'($urandom_range(0, 1));
          mc_rd_valid = ($urandom_range(0, 2) != 0);
          if ((mc_rd_valid && m_cnt + 1 >= target) || m_cnt >= target)
            mc_tx_done = 1'($urandom_range(0, 1));
        end
        default: begin
          req_valid   = 1'($urandom_range(0, 1));
          resp_ready  = ($urandom_range(0, 2) == 0);
          mc_tx_done  = ($urandom_range(0, 3) == 0);
          mc_rd_valid = ($urandom_range(0, 3) == 0);
        end
      endcase
    end
    @(posedge clk); #2;
    req_valid = 1'b0; mc_tx_done = 1'b0; mc_rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
